// File: rtl/jtdd_pkg.sv
// jtdd_pkg -- timing constants shared by the DD video pipeline.
//
// The default raster geometry lives here so that the object and scroll engines
// and the video timer all work from one set of numbers.
// Contents:
//   cnt_t        9-bit raster counter type (hdump / vdump)
//   DD_*         default raster geometry
//   in_window()  half-open range test [lo, lo+len) on a counter value
package jtdd_pkg;

  typedef logic [8:0] cnt_t;

  localparam int DD_HTOTAL   = 384;  // pixels per line
  localparam int DD_HB_START = 256;  // first blanked pixel
  localparam int DD_HS_START = 288;  // first pixel with HS
  localparam int DD_HS_LEN   = 32;   // HS width in pixels
  localparam int DD_VSTART   = 8;    // first vdump value of a frame
  localparam int DD_VTOTAL   = 272;  // lines per frame
  localparam int DD_VACTIVE  = 240;  // visible lines from DD_VSTART
  localparam int DD_VS_LINE  = 256;  // first line with VS
  localparam int DD_VS_LEN   = 3;    // VS width in lines

  function automatic logic in_window(input cnt_t val, input int lo, input int len);
    return (int'(val) >= lo) && (int'(val) < lo + len);
  endfunction

endpackage

// File: rtl/jtdd_vtimer_cnt.sv
// jtdd_vtimer_cnt -- modulo counter running START..LAST with carry chaining.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (count returns to START)
//   cin        advance enable
//   cnt        current count (registered)
//   cnt_next   value the count takes on the next clock edge
//   cout       high when cin is high and the count is about to wrap
module jtdd_vtimer_cnt
  import jtdd_pkg::*;
#(
  parameter cnt_t START = '0,
  parameter cnt_t LAST  = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic cin,
  output cnt_t cnt,
  output cnt_t cnt_next,
  output logic cout
);

  always_comb begin
    cout     = cin && (cnt == LAST);
    cnt_next = cnt;
    if (cin) cnt_next = (cnt == LAST) ? START : cnt + 9'd1;
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) cnt <= START;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/jtdd_vtimer.sv
// jtdd_vtimer -- DD main board video timing generator.
//
// Derives the 6 MHz pixel enable from cen12, runs the H/V dump counters and
// produces blanking, sync, frame and the VBL/IMS interrupt sources.
// Optional build macro: JTDD_VTIMER_DBGFREEZE_EN adds a 'freeze' input that
// pauses the raster (counters and flags hold, pxl_cen keeps pulsing).
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   cen12     12 MHz clock enable
//   freeze    (macro only) hold the raster while high
//   pxl_cen   6 MHz pixel enable, one clk wide
//   hdump     horizontal pixel counter, 0..HTOTAL-1
//   vdump     vertical line counter, VSTART..VSTART+VTOTAL-1
//   HBL, VBL  horizontal / vertical blank
//   HS, VS    horizontal / vertical sync
//   IMS       vdump[3], feeds the CPU FIRQ edge detector
//   frame     one pixel-period pulse on the first pixel of each frame
module jtdd_vtimer
  import jtdd_pkg::*;
#(
  parameter int HTOTAL   = DD_HTOTAL,
  parameter int HB_START = DD_HB_START,
  parameter int HS_START = DD_HS_START,
  parameter int HS_LEN   = DD_HS_LEN,
  parameter int VSTART   = DD_VSTART,
  parameter int VTOTAL   = DD_VTOTAL,
  parameter int VACTIVE  = DD_VACTIVE,
  parameter int VS_LINE  = DD_VS_LINE,
  parameter int VS_LEN   = DD_VS_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic cen12,
`ifdef JTDD_VTIMER_DBGFREEZE_EN
  input  logic freeze,
`endif
  output logic pxl_cen,
  output cnt_t hdump,
  output cnt_t vdump,
  output logic HBL,
  output logic VBL,
  output logic IMS,
  output logic HS,
  output logic VS,
  output logic frame
);

  localparam cnt_t VSTART_V = cnt_t'(VSTART);

  logic toggle;
  logic advance;
  cnt_t h_next, v_next;
  logic h_wrap, v_wrap;

  // Toggle starts low so the first cen12 after reset is swallowed and the
  // second one produces the first pixel enable.
  always_ff @(posedge clk, posedge rst) begin
    if (rst)        toggle <= 1'b0;
    else if (cen12) toggle <= ~toggle;
  end

  assign pxl_cen = cen12 & toggle;

`ifdef JTDD_VTIMER_DBGFREEZE_EN
  assign advance = pxl_cen & ~freeze;
`else
  assign advance = pxl_cen;
`endif

  jtdd_vtimer_cnt #(
    .START (9'd0),
    .LAST  (cnt_t'(HTOTAL - 1))
  ) u_hcnt (
    .clk      (clk),
    .rst      (rst),
    .cin      (advance),
    .cnt      (hdump),
    .cnt_next (h_next),
    .cout     (h_wrap)
  );

  jtdd_vtimer_cnt #(
    .START (VSTART_V),
    .LAST  (cnt_t'(VSTART + VTOTAL - 1))
  ) u_vcnt (
    .clk      (clk),
    .rst      (rst),
    .cin      (h_wrap),
    .cnt      (vdump),
    .cnt_next (v_next),
    .cout     (v_wrap)
  );

  // Flags are decoded from the counters' next values so they switch on the
  // same edge as hdump/vdump. A vertical wrap implies a horizontal wrap, so
  // v_wrap marks exactly the transition into (0, VSTART) after a full frame.
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      HBL   <= 1'b0;
      HS    <= 1'b0;
      VBL   <= 1'b0;
      VS    <= 1'b0;
      IMS   <= VSTART_V[3];
      frame <= 1'b0;
    end else if (advance) begin
      HBL   <= int'(h_next) >= HB_START;
      HS    <= in_window(h_next, HS_START, HS_LEN);
      VBL   <= int'(v_next) >= VSTART + VACTIVE;
      VS    <= in_window(v_next, VS_LINE, VS_LEN);
      IMS   <= v_next[3];
      frame <= v_wrap;
    end
  end

endmodule
